// File: rtl/io_ring_pkg.sv
// io_ring_pkg: shared types, default parameters and counter sizing for the IO ring.
// The optional glitch filter is enabled by defining IO_RING_FILTER_EN.
package io_ring_pkg;

  typedef enum logic {
    HOLD   = 1'b0,
    ACTIVE = 1'b1
  } io_ring_state_t;

  localparam int N_IN_DEF        = 18;
  localparam int N_OUT_DEF       = 12;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILTER_LEN_DEF  = 4;
  localparam int HOLD_CYCLES_DEF = 16;

  // Bits needed to hold a count from 0 up to max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/io_ring_ctrl_in_chan.sv
// io_in_chan: one input pad channel -- synchroniser, optional glitch filter and
// edge detector. The glitch filter exists only when IO_RING_FILTER_EN is defined;
// otherwise the synchronised level is registered straight into in_o.
module io_in_chan
  import io_ring_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef IO_RING_FILTER_EN
  ,
  parameter int FILTER_LEN  = FILTER_LEN_DEF
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_i,
  input  logic ready_i,
  output logic in_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_bit;
  logic                   in_q, in_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Shift the raw pad level one stage deeper into the synchroniser each edge.
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};

`ifdef IO_RING_FILTER_EN
  localparam int CNT_W = cnt_width(FILTER_LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has disagreed with in_o for FILTER_LEN edges in a row.
  always_comb begin
    cnt_d = '0;
    in_d  = in_q;
    if (sync_bit != in_q) begin
      if (int'(cnt_q) + 1 >= FILTER_LEN) begin
        in_d = sync_bit;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Filter run-length counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  // Without the filter the synchronised level is taken as-is.
  always_comb in_d = sync_bit;
`endif

  // Edge pulses are raised together with the in_o change, but only once the ring is ready.
  always_comb begin
    rise_d = ready_i &  in_d & ~in_q;
    fall_d = ready_i & ~in_d &  in_q;
  end

  // Synchroniser, filtered level and edge pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      in_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      in_q   <= in_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign in_o   = in_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/io_ring_ctrl.sv
// io_ring_ctrl: IO ring controller. Generates the core reset (async assert,
// sync release), holds output pads in a safe state for HOLD_CYCLES after the
// core leaves reset, then registers core drive data/enables onto the pads.
// Input pads are synchronised, optionally glitch filtered (IO_RING_FILTER_EN)
// and edge detected per channel.
module io_ring_ctrl
  import io_ring_pkg::*;
#(
  parameter int N_IN        = N_IN_DEF,
  parameter int N_OUT       = N_OUT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic             clk_i,
  input  logic             resetn,
  input  logic [N_IN-1:0]  pad_in_i,
  output logic [N_IN-1:0]  in_o,
  output logic [N_IN-1:0]  rise_o,
  output logic [N_IN-1:0]  fall_o,
  output logic             core_resetn_o,
  input  logic [N_OUT-1:0] core_out_i,
  input  logic [N_OUT-1:0] core_oe_i,
  output logic [N_OUT-1:0] pad_out_o,
  output logic [N_OUT-1:0] pad_oe_o,
  output logic             ready_o
);

  localparam int HOLD_W = cnt_width(HOLD_CYCLES);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 1 || FILTER_LEN > 255 ||
      HOLD_CYCLES < 0 || HOLD_CYCLES > 65535) begin : g_bad_param
    $error("io_ring_ctrl: parameter outside its legal range");
  end

  logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
  logic                   core_rst_n;

  io_ring_state_t         state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                   ready_q, ready_d;
  logic [N_OUT-1:0]       pad_out_q, pad_out_d;
  logic [N_OUT-1:0]       pad_oe_q, pad_oe_d;

  assign core_rst_n = rst_sync_q[SYNC_STAGES-1];

  // Shift ones into the reset synchroniser so release lands SYNC_STAGES edges after resetn.
  always_comb rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};

  // Reset synchroniser: cleared immediately by resetn, released on the clock.
  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) rst_sync_q <= '0;
    else         rst_sync_q <= rst_sync_d;
  end

  // Next-state logic: count hold edges once the core is out of reset, pads forced safe until ACTIVE.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      HOLD: begin
        if (core_rst_n) begin
          if (int'(hold_cnt_q) + 1 >= HOLD_CYCLES) begin
            state_d    = ACTIVE;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      ACTIVE: begin
        state_d = ACTIVE;
      end
      default: begin
        state_d    = HOLD;
        hold_cnt_d = '0;
      end
    endcase
    ready_d   = (state_d == ACTIVE);
    pad_out_d = (state_q == ACTIVE) ? core_out_i : '0;
    pad_oe_d  = (state_q == ACTIVE) ? core_oe_i  : '0;
  end

  // Hold/active FSM with its registered outputs.
  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      ready_q    <= 1'b0;
      pad_out_q  <= '0;
      pad_oe_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      ready_q    <= ready_d;
      pad_out_q  <= pad_out_d;
      pad_oe_q   <= pad_oe_d;
    end
  end

  assign core_resetn_o = core_rst_n;
  assign ready_o       = ready_q;
  assign pad_out_o     = pad_out_q;
  assign pad_oe_o      = pad_oe_q;

  // Edge pulses are gated with the ready value that will be visible alongside them.
  for (genvar i = 0; i < N_IN; i++) begin : g_chan
    io_in_chan #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef IO_RING_FILTER_EN
      ,
      .FILTER_LEN (FILTER_LEN)
`endif
    ) u_chan (
      .clk_i  (clk_i),
      .rst_ni (resetn),
      .pad_i  (pad_in_i[i]),
      .ready_i(ready_d),
      .in_o   (in_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i])
    );
  end

endmodule
